// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display reader: segment
// lookup table, FSM state encoding and datapath widths.
package seg7_pkg;

    localparam int SEG_W     = 7;   // segments a..g, bit0 = a
    localparam int NIB_W     = 4;   // one hex digit
    localparam int TBL_DEPTH = 16;  // hex codes 0..F
    localparam int CNT_W     = 4;   // holds STABLE_CYCLES up to 15

    // Active-high abcdefg patterns, entry h at [h*SEG_W +: SEG_W].
    // Listed from F (MSB) down to 0 (LSB).
    localparam logic [TBL_DEPTH*SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no single digit strobed
        ST_TRACK = 2'd1,   // counting identical samples
        ST_HELD  = 2'd2    // captured, waiting for the sample to change
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high segment pattern to its hex nibble; hit is low
// when the pattern is not one of the 16 table entries.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [NIB_W-1:0] nibble,
    output logic             hit
);

    logic [TBL_DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < TBL_DEPTH; gi++) begin : g_match
            assign match[gi] = (pattern == SEG_TABLE[gi*SEG_W +: SEG_W]);
        end
    endgenerate

    // Table entries are unique, so at most one match bit is set.
    always_comb begin
        nibble = '0;
        hit    = |match;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            if (match[i]) nibble = NIB_W'(i);
        end
    end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment display: waits for a digit strobe
// with a stable pattern for STABLE_CYCLES samples, then latches the
// decoded nibble for that digit.
// Optional macro SEG7_READER_BLANK_EN: an all-off pattern marks the
// digit blank (invalid, no error) instead of flagging an error.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEG_W-1:0]            seg_n,
    input  logic [N_DIGITS-1:0]         dig_sel_n,
    input  logic                        err_clr,
    output logic [NIB_W*N_DIGITS-1:0]   value,
    output logic [N_DIGITS-1:0]         digit_valid,
    output logic [N_DIGITS-1:0]         err,
    output logic                        update,
    output logic [$clog2(N_DIGITS)-1:0] update_digit
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Registered inputs and the sample currently being tracked
    logic [SEG_W-1:0]    seg_n_reg;
    logic [N_DIGITS-1:0] dig_sel_n_reg;
    logic [SEG_W-1:0]    trk_seg_n_reg;
    logic [N_DIGITS-1:0] trk_sel_n_reg;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic [NIB_W*N_DIGITS-1:0] value_reg, value_next;
    logic [N_DIGITS-1:0]       valid_reg, valid_next;
    logic [N_DIGITS-1:0]       err_reg, err_next;
    logic                      update_reg;
    logic [IDX_W-1:0]          update_digit_reg;

    logic [SEG_W-1:0]    pattern;
    logic [N_DIGITS-1:0] sel_act;
    logic                is_strobe;
    logic                same_sample;
    logic [IDX_W-1:0]    strobe_idx;
    logic                capture;
    logic                load_trk;
    logic [NIB_W-1:0]    dec_nibble;
    logic                dec_hit;

    assign pattern     = ~seg_n_reg;
    assign sel_act     = ~dig_sel_n_reg;
    assign is_strobe   = $onehot(sel_act);
    assign same_sample = (dig_sel_n_reg == trk_sel_n_reg) &&
                         (seg_n_reg == trk_seg_n_reg);

    // Index of the single active strobe (meaningful only when is_strobe)
    always_comb begin
        strobe_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel_act[i]) strobe_idx = IDX_W'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (pattern),
        .nibble  (dec_nibble),
        .hit     (dec_hit)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (is_strobe) state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (!is_strobe)                      state_next = ST_IDLE;
                else if (!same_sample)               state_next = ST_TRACK;
                else if (count_reg == STABLE_LAST)   state_next = ST_HELD;
            end
            ST_HELD: begin
                if (!is_strobe)        state_next = ST_IDLE;
                else if (!same_sample) state_next = ST_TRACK;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: sample counter, tracking load and capture strobe
    always_comb begin
        count_next = count_reg;
        load_trk   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                count_next = is_strobe ? CNT_W'(1) : '0;
                load_trk   = is_strobe;
            end
            ST_TRACK, ST_HELD: begin
                if (!is_strobe) begin
                    count_next = '0;
                end else if (!same_sample) begin
                    count_next = CNT_W'(1);
                    load_trk   = 1'b1;
                end else if (state_reg == ST_TRACK) begin
                    count_next = count_reg + 1'b1;
                    capture    = (count_reg == STABLE_LAST);
                end
            end
            default: count_next = '0;
        endcase
    end

    // Result update on capture; an error set wins over err_clr
    always_comb begin
        value_next = value_reg;
        valid_next = valid_reg;
        err_next   = err_clr ? '0 : err_reg;
        if (capture) begin
            if (dec_hit) begin
                value_next[int'(strobe_idx)*NIB_W +: NIB_W] = dec_nibble;
                valid_next[strobe_idx] = 1'b1;
            end
`ifdef SEG7_READER_BLANK_EN
            else if (pattern == '0) begin
                valid_next[strobe_idx] = 1'b0;
            end
`endif
            else begin
                valid_next[strobe_idx] = 1'b0;
                err_next[strobe_idx]   = 1'b1;
            end
        end
    end

    // Input sampling, tracking registers and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n_reg        <= '0;
            dig_sel_n_reg    <= '0;
            trk_seg_n_reg    <= '0;
            trk_sel_n_reg    <= '0;
            count_reg        <= '0;
            value_reg        <= '0;
            valid_reg        <= '0;
            err_reg          <= '0;
            update_reg       <= 1'b0;
            update_digit_reg <= '0;
        end else begin
            seg_n_reg     <= seg_n;
            dig_sel_n_reg <= dig_sel_n;
            if (load_trk) begin
                trk_seg_n_reg <= seg_n_reg;
                trk_sel_n_reg <= dig_sel_n_reg;
            end
            count_reg  <= count_next;
            value_reg  <= value_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
            update_reg <= capture;
            if (capture) update_digit_reg <= strobe_idx;
        end
    end

    assign value        = value_reg;
    assign digit_valid  = valid_reg;
    assign err          = err_reg;
    assign update       = update_reg;
    assign update_digit = update_digit_reg;

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed digits.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..15, giving the consecutive identical samples required before capture.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seg_n  input  7  active-low segments, bit0=a .. bit6=g.
REQ-006 SHALL have port dig_sel_n  input  N_DIGITS  active-low digit strobes.
REQ-007 SHALL have port err_clr  input  1  clears sticky errors.
REQ-008 SHALL have port value  output  4*N_DIGITS  decoded hex nibbles; digit k occupies [4k+3:4k].
REQ-009 SHALL have port digit_valid  output  N_DIGITS  per-digit valid flag.
REQ-010 SHALL have port err  output  N_DIGITS  sticky per-digit unrecognised-pattern flag.
REQ-011 SHALL have port update  output  1  one-cycle capture pulse.
REQ-012 SHALL have port update_digit  output  $clog2(N_DIGITS)  index of the digit captured on the last update.

Function
REQ-013 SHALL register seg_n and dig_sel_n once before any comparison; pattern = ~seg_n.
REQ-014 SHALL treat a sample as a strobe only when exactly one dig_sel_n bit is low; zero or several low bits are idle.
REQ-015 SHALL implement an FSM with states IDLE (no strobe), TRACK (counting), and HELD (captured, waiting for change).
REQ-016 SHALL go IDLE->TRACK on a strobe sample, with count=1.
REQ-017 In TRACK, an identical (sel, pattern) sample SHALL increment the count; a different strobe sample SHALL restart the count at 1; an idle sample SHALL return the FSM to IDLE.
REQ-018 SHALL capture and enter HELD when the count reaches STABLE_CYCLES.
REQ-019 SHALL leave HELD on any change: to TRACK on a new strobe sample, to IDLE on an idle sample; no repeat capture occurs while the sample is unchanged.
REQ-020 SHALL assert update in the cycle after edge E0+STABLE_CYCLES when the inputs are set up before edge E0 and held, for one cycle only.
REQ-021 On a capture where the pattern matches hex code h (0-F table), the block SHALL load value nibble k<=h, set digit_valid[k]<=1, pulse update, and set update_digit<=k.
REQ-022 On a capture with a non-matching pattern, the block SHALL set err[k], clear digit_valid[k], leave value nibble k unchanged, and still pulse update.
REQ-023 When err_clr and an err set coincide in the same cycle, the set SHALL win; otherwise err_clr SHALL clear all err bits.

Reset
REQ-024 While reset is high, value, digit_valid, err, update, update_digit, the count and the input registers SHALL all be 0, and the FSM SHALL be IDLE.
REQ-025 A reset asserted mid-window SHALL discard the partial count; a full new window is required after release.

Configuration
REQ-026 SHALL provide macro SEG7_READER_BLANK_EN.
REQ-027 With SEG7_READER_BLANK_EN defined, a captured all-off pattern SHALL clear digit_valid[k] without setting err[k].
REQ-028 Without SEG7_READER_BLANK_EN, an all-off pattern SHALL be an unrecognised pattern per REQ-022.

Structure
REQ-029 SHALL place the 16-entry segment table (abcdefg, active-high, 0=0111111 .. F=1110001), the FSM state typedef and the table width constants in package seg7_pkg.
REQ-030 SHALL place pattern-to-nibble lookup, with hit flag, in sub-module seg7_pattern_decode; seg7_reader SHALL instantiate it once.

Verification
REQ-031 Digit 0 capture: dig_sel_n=1110, seg_n=0000000 (8) held 6 cycles -> value[3:0]=8, digit_valid=0001, one update pulse with update_digit=0, in the 5th cycle after first edge.
REQ-032 Glitch rejection: digit 1 pattern for "3" held 3 cycles, then "5" held 4 cycles -> no update for "3"; one update with value[7:4]=5.
REQ-033 Error and clear: digit 2, seg_n=~1000000 (dash) held 4 cycles -> err=0100, digit_valid[2]=0; err_clr pulsed in the error-set cycle -> err stays 0100; err_clr pulsed later -> err=0000.
REQ-034 Multiple strobes: dig_sel_n=1100 held 10 cycles -> no update, all outputs unchanged.
REQ-035 Blank: seg_n=1111111 on digit 3 held 4 cycles -> with macro, digit_valid[3]=0 and err=0; without macro, err[3]=1.
REQ-036 Reset mid-window: 2 stable cycles, then reset for 1 cycle, then 2 more stable cycles -> no update; all outputs 0.
